// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and decode helper for the mem_access load/store stage
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} mem_state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} mem_size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic        lb;
    logic        lh;
    logic        lw;
    logic        lbu;
    logic        lhu;
    logic        sb;
    logic        sh;
    logic        sw;
    logic [31:0] imm;
  } instructions;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    mem_size_t size;
    logic      is_unsigned;
  } mem_dec_t;

  // Several flags at once is a decode error; resolve with fixed priority lw>lh>lb>lhu>lbu>sw>sh>sb.
  function automatic mem_dec_t decode_mem(input instructions ins);
    mem_dec_t d;
    d.is_mem      = 1'b1;
    d.is_store    = 1'b0;
    d.size        = SZ_W;
    d.is_unsigned = 1'b0;
    if (ins.lw) begin
      d.size = SZ_W;
    end else if (ins.lh) begin
      d.size = SZ_H;
    end else if (ins.lb) begin
      d.size = SZ_B;
    end else if (ins.lhu) begin
      d.size        = SZ_H;
      d.is_unsigned = 1'b1;
    end else if (ins.lbu) begin
      d.size        = SZ_B;
      d.is_unsigned = 1'b1;
    end else if (ins.sw) begin
      d.is_store = 1'b1;
    end else if (ins.sh) begin
      d.is_store = 1'b1;
      d.size     = SZ_H;
    end else if (ins.sb) begin
      d.is_store = 1'b1;
      d.size     = SZ_B;
    end else begin
      d.is_mem = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// rtl/mem_access_lsu_align.sv - byte-lane steering, load extension and alignment check
module lsu_align
  import mem_access_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_we       = BE_WORD;
    o_wdata    = i_rs2;
    o_load     = i_rdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        o_we    = BE_BYTE << i_off;
        o_wdata = {4{i_rs2[7:0]}};
        o_load  = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_we       = BE_HALF << i_off;
        o_wdata    = {2{i_rs2[15:0]}};
        o_load     = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        o_misalign = i_off[0];
      end
      default: begin
        o_misalign = |i_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store execute stage: address generation, FSM and memory handshake
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enabled,
  input  instructions       instr,
  input  logic [31:0]       rs1,
  input  logic [31:0]       rs2,
  output logic              completed,
  output logic [31:0]       rd,
  output logic              misalign,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  mem_state_t        r_state;
  logic              r_req;
  logic              r_misalign;
  logic              r_store;
  logic              r_unsigned;
  mem_size_t         r_size;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_we;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd;

  logic [31:0] w_ea;
  mem_dec_t    w_dec;
  logic        w_in_req;
  logic        w_accept;
  mem_size_t   w_size;
  logic        w_uns;
  logic [1:0]  w_off;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_load;
  logic        w_misalign;
  logic        w_unused;

  assign w_ea     = rs1 + instr.imm;
  assign w_dec    = decode_mem(instr);
  assign w_in_req = (r_state == REQ);
  assign w_accept = enabled && !w_in_req;
  assign w_unused = &{1'b0, w_ea[31:ADDR_W+2]};

  // One aligner serves both paths: incoming decode on accept, latched access while in REQ.
  assign w_size = w_in_req ? r_size     : w_dec.size;
  assign w_uns  = w_in_req ? r_unsigned : w_dec.is_unsigned;
  assign w_off  = w_in_req ? r_off      : w_ea[1:0];

  lsu_align u_align (
    .i_size     (w_size),
    .i_unsigned (w_uns),
    .i_off      (w_off),
    .i_rs2      (rs2),
    .i_rdata    (mem_rdata),
    .o_we       (w_we),
    .o_wdata    (w_wdata),
    .o_load     (w_load),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_misalign <= 1'b0;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_W;
      r_off      <= 2'd0;
      r_addr     <= '0;
      r_we       <= 4'd0;
      r_wdata    <= 32'd0;
      r_rd       <= 32'd0;
    end else if (w_accept) begin
      r_misalign <= 1'b0;
      r_store    <= w_dec.is_store;
      r_unsigned <= w_dec.is_unsigned;
      r_size     <= w_dec.size;
      r_off      <= w_ea[1:0];
      if (!w_dec.is_mem) begin
        r_rd    <= 32'd0;
        r_state <= DONE;
      end else if (w_misalign) begin
        r_rd       <= 32'd0;
        r_misalign <= 1'b1;
        r_state    <= DONE;
      end else begin
        r_req   <= 1'b1;
        r_addr  <= w_ea[ADDR_W+1:2];
        r_we    <= w_dec.is_store ? w_we : 4'd0;
        r_wdata <= w_dec.is_store ? w_wdata : 32'd0;
        r_state <= REQ;
      end
    end else if (w_in_req) begin
      if (mem_ready) begin
        r_req   <= 1'b0;
        r_rd    <= r_store ? 32'd0 : w_load;
        r_state <= DONE;
      end
    end else begin
      r_state <= IDLE;
    end
  end

  assign completed = (r_state == DONE);
  assign rd        = r_rd;
  assign misalign  = r_misalign;
  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [7:0] F_LB  = 8'h80;
  localparam logic [7:0] F_LH  = 8'h40;
  localparam logic [7:0] F_LW  = 8'h20;
  localparam logic [7:0] F_LBU = 8'h10;
  localparam logic [7:0] F_LHU = 8'h08;
  localparam logic [7:0] F_SB  = 8'h04;
  localparam logic [7:0] F_SH  = 8'h02;
  localparam logic [7:0] F_SW  = 8'h01;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enabled;
  instructions instr;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        completed;
  logic [31:0] rd;
  logic        misalign;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_access #(.ADDR_W(15)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enabled   (enabled),
    .instr     (instr),
    .rs1       (rs1),
    .rs2       (rs2),
    .completed (completed),
    .rd        (rd),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic instructions mk(input logic [7:0] flags, input logic [31:0] imm);
    instructions ins;
    ins = {flags, imm};
    return ins;
  endfunction

  task automatic issue(input logic [7:0] flags, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    instr   = mk(flags, imm);
    rs1     = a;
    rs2     = b;
    enabled = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
  endtask

  task automatic ready(input logic [31:0] data);
    mem_ready = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  logic [7:0]  ld_flag [4];
  logic [31:0] ld_imm  [4];
  logic [31:0] ld_exp  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ld_flag = '{F_LB, F_LBU, F_LH, F_LHU};
    ld_imm  = '{32'd3, 32'd3, 32'd2, 32'd0};
    ld_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};

    rstn = 1'b0; enabled = 1'b0; instr = '0; rs1 = 0; rs2 = 0;
    mem_ready = 1'b0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_completed", {31'd0, completed}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_we", {28'd0, mem_we}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // sw: one accept edge, then ready edge -> completed
    issue(F_SW, 32'd4, 32'h100, 32'hDEADBEEF);
    check("sw_req", {31'd0, mem_req}, 32'd1);
    check("sw_addr", {17'd0, mem_addr}, 32'h41);
    check("sw_we", {28'd0, mem_we}, 32'hF);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_early_cpl", {31'd0, completed}, 32'd0);
    ready(32'h0);
    check("sw_cpl", {31'd0, completed}, 32'd1);
    check("sw_req_drop", {31'd0, mem_req}, 32'd0);
    check("sw_rd", rd, 32'd0);
    @(negedge clk);
    check("sw_cpl_pulse", {31'd0, completed}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      issue(ld_flag[i], ld_imm[i], 32'h200, 32'h0);
      check($sformatf("ld%0d_we", i), {28'd0, mem_we}, 32'd0);
      check($sformatf("ld%0d_addr", i), {17'd0, mem_addr}, 32'h80);
      ready(32'h80FF7F01);
      check($sformatf("ld%0d_cpl", i), {31'd0, completed}, 32'd1);
      check($sformatf("ld%0d_rd", i), rd, ld_exp[i]);
    end

    issue(F_SB, 32'd3, 32'h200, 32'h12345678);
    check("sb_we", {28'd0, mem_we}, 32'h8);
    check("sb_wdata", mem_wdata, 32'h78787878);
    ready(32'h0);
    issue(F_SH, 32'd2, 32'h200, 32'h12345678);
    check("sh_we", {28'd0, mem_we}, 32'hC);
    check("sh_wdata", mem_wdata, 32'h56785678);
    ready(32'h0);
    check("sh_cpl", {31'd0, completed}, 32'd1);

    // misaligned accesses finish in one cycle with no memory request
    issue(F_LW, 32'd2, 32'h100, 32'h0);
    check("lw_mis_cpl", {31'd0, completed}, 32'd1);
    check("lw_mis_flag", {31'd0, misalign}, 32'd1);
    check("lw_mis_req", {31'd0, mem_req}, 32'd0);
    check("lw_mis_rd", rd, 32'd0);
    issue(F_SH, 32'd1, 32'h100, 32'h0);
    check("sh_mis_cpl", {31'd0, completed}, 32'd1);
    check("sh_mis_flag", {31'd0, misalign}, 32'd1);
    check("sh_mis_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("mis_hold", {31'd0, misalign}, 32'd1);

    issue(8'h00, 32'd0, 32'h0, 32'h0);
    check("nop_cpl", {31'd0, completed}, 32'd1);
    check("nop_mis_clear", {31'd0, misalign}, 32'd0);
    check("nop_req", {31'd0, mem_req}, 32'd0);

    // lw and sb both set: lw wins
    issue(F_LW | F_SB, 32'd0, 32'h104, 32'hFFFFFFFF);
    check("prio_we", {28'd0, mem_we}, 32'd0);
    check("prio_addr", {17'd0, mem_addr}, 32'h41);
    ready(32'h00000055);
    check("prio_rd", rd, 32'h55);

    // stalled memory: outputs stable, enabled ignored
    issue(F_LW, 32'd0, 32'h300, 32'h0);
    for (int i = 0; i < 5; i++) begin
      instr   = mk(F_SW, 32'd0);
      rs1     = 32'h500;
      enabled = (i == 1 || i == 3);
      @(negedge clk);
      enabled = 1'b0;
      check($sformatf("stall%0d_req", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("stall%0d_addr", i), {17'd0, mem_addr}, 32'hC0);
      check($sformatf("stall%0d_we", i), {28'd0, mem_we}, 32'd0);
      check($sformatf("stall%0d_cpl", i), {31'd0, completed}, 32'd0);
    end
    ready(32'hCAFEF00D);
    check("stall_cpl", {31'd0, completed}, 32'd1);
    check("stall_rd", rd, 32'hCAFEF00D);
    @(negedge clk);
    check("stall_noqueue_req", {31'd0, mem_req}, 32'd0);
    check("stall_noqueue_cpl", {31'd0, completed}, 32'd0);

    // asynchronous reset while a request is in flight
    issue(F_LW, 32'd0, 32'h104, 32'h0);
    check("rstreq_req", {31'd0, mem_req}, 32'd1);
    check("rstreq_rd_held", rd, 32'hCAFEF00D);
    rstn = 1'b0;
    #1;
    check("rstreq_req0", {31'd0, mem_req}, 32'd0);
    check("rstreq_cpl0", {31'd0, completed}, 32'd0);
    check("rstreq_rd0", rd, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(F_LW, 32'd8, 32'h100, 32'h0);
    check("after_rst_addr", {17'd0, mem_addr}, 32'h42);
    ready(32'h11223344);
    check("after_rst_rd", rd, 32'h11223344);

    // back-to-back accept in DONE
    issue(F_LBU, 32'd1, 32'h200, 32'h0);
    ready(32'h80FF7F01);
    check("b2b_first_cpl", {31'd0, completed}, 32'd1);
    check("b2b_first_rd", rd, 32'h7F);
    issue(F_SW, 32'd0, 32'h10, 32'hA5A5A5A5);
    check("b2b_req", {31'd0, mem_req}, 32'd1);
    check("b2b_cpl_low", {31'd0, completed}, 32'd0);
    check("b2b_addr", {17'd0, mem_addr}, 32'h4);
    ready(32'h0);
    check("b2b_second_cpl", {31'd0, completed}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
